// File: rtl/wb_arb.sv
`default_nettype none
// =============================================================================
// wb_arb : GPR write-port arbiter. Pipeline writeback always wins; secondary
//          results queue in a small FIFO and drain into bubbles.
// Rev 1.0
// =============================================================================
module wb_arb #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_i_wreg,
  input  logic [4:0]  wb_i_waddr,
  input  logic [31:0] wb_i_wdata,
  input  logic        sec_valid,
  output logic        sec_ready,
  input  logic [4:0]  sec_waddr,
  input  logic [31:0] sec_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_req,
  input  logic [4:0]  q_addr,
  output logic        pend_hit
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [SW-1:0] C_LIMIT = SW'(STARVE_LIMIT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  logic [4:0]    mem_addr_q [DEPTH];
  logic [31:0]   mem_data_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [1:0]    state_q, state_d;
  logic          stall_req_q, stall_req_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;

  logic          w_full, w_empty, w_prim, w_push, w_pop;
  logic [AW-1:0] w_idx;

  assign w_full    = (count_q == C_DEPTH);
  assign w_empty   = (count_q == '0);
  assign sec_ready = ~w_full;
  // Zero-address secondary requests are acknowledged but never stored.
  assign w_push    = sec_valid && sec_ready && (sec_waddr != 5'd0);
  assign w_prim    = wb_i_wreg && (wb_i_waddr != 5'd0);
  assign w_pop     = ~w_prim && ~w_empty;

  always_comb begin
    rd_ptr_d   = rd_ptr_q + AW'(w_pop);
    wr_ptr_d   = wr_ptr_q + AW'(w_push);
    count_d    = count_q + CW'(w_push) - CW'(w_pop);
    rf_we_d    = w_prim | w_pop;
    rf_waddr_d = 5'd0;
    rf_wdata_d = 32'd0;
    if (w_prim) begin
      rf_waddr_d = wb_i_waddr;
      rf_wdata_d = wb_i_wdata;
    end else if (w_pop) begin
      rf_waddr_d = mem_addr_q[rd_ptr_q];
      rf_wdata_d = mem_data_q[rd_ptr_q];
    end
    starve_cnt_d = starve_cnt_q;
    if (w_empty || w_pop) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < C_LIMIT) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_push) state_d = S_WAIT;
      S_WAIT: begin
        if (count_d == '0)                 state_d = S_IDLE;
        else if (starve_cnt_d == C_LIMIT)  state_d = S_STALL;
      end
      S_STALL: if (w_pop) state_d = (count_d == '0) ? S_IDLE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_req_d = (state_d == S_STALL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      stall_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_req_q <= stall_req_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      starve_cnt_q <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= 5'd0;
      rf_wdata_q   <= 32'd0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  // Storage needs no reset: validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_addr_q[wr_ptr_q] <= sec_waddr;
      mem_data_q[wr_ptr_q] <= sec_wdata;
    end
  end

  always_comb begin
    pend_hit = 1'b0;
    w_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = rd_ptr_q + AW'(i);
      if ((CW'(i) < count_q) && (mem_addr_q[w_idx] == q_addr)) pend_hit = 1'b1;
    end
    if (q_addr == 5'd0) pend_hit = 1'b0;
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign stall_req = stall_req_q;

endmodule
`default_nettype wire
